// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, result-ready
// constants and the EX-stage opcodes from which start/signed_div are derived.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'b00,
    DIV_DZERO = 2'b01,
    DIV_BUSY  = 2'b10,
    DIV_DONE  = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the
// divisor from the top WIDTH+1 bits and shift the new quotient bit into dvd.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           borrow;

  assign trial = {rem_i, dvd_i[WIDTH-1]};
  assign diff  = trial - {1'b0, dsr_i};
  // rem < dsr keeps trial below 2*dsr, so bit WIDTH of diff is set exactly on a borrow.
  assign borrow = diff[WIDTH];

  assign rem_o = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_o = {dvd_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// result = {remainder, quotient}; stall_req holds the pipeline while in flight.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req,
  output div_state_e         dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   step_rem, step_dvd;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept, iterate, finish_busy, finish_dz;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next state: annul beats everything; dropping start aborts an unfinished division.
  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE:  if (start) state_d = (opdata2 == '0) ? DIV_DZERO : DIV_BUSY;
        DIV_DZERO: state_d = start ? DIV_DONE : DIV_IDLE;
        DIV_BUSY: begin
          if (!start)                     state_d = DIV_IDLE;
          else if (cnt_q == CW'(WIDTH))   state_d = DIV_DONE;
        end
        DIV_DONE:  if (!start) state_d = DIV_IDLE;
        default:   state_d = DIV_IDLE;
      endcase
    end
  end

  // Outputs and datapath controls
  always_comb begin
    result      = result_q;
    ready       = ready_q;
    stall_req   = start & ~ready_q;
    dbg_state   = state_q;
    accept      = (state_q == DIV_IDLE)  && (state_d == DIV_BUSY);
    iterate     = (state_q == DIV_BUSY)  && (state_d == DIV_BUSY);
    finish_busy = (state_q == DIV_BUSY)  && (state_d == DIV_DONE);
    finish_dz   = (state_q == DIV_DZERO) && (state_d == DIV_DONE);
  end

  always_comb begin
    mag1    = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    mag2    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;

    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = (state_d == DIV_DONE) ? DivResultReady : DivResultNotReady;

    if (accept) begin
      cnt_d     = '0;
      rem_d     = '0;
      dvd_d     = mag1;
      dsr_d     = mag2;
      neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
      neg_rem_d = signed_div & opdata1[WIDTH-1];
    end else if (iterate) begin
      cnt_d = cnt_q + 1'b1;
      rem_d = step_rem;
      dvd_d = step_dvd;
    end

    if (finish_busy)    result_d = {rem_fix, quo_fix};
    else if (finish_dz) result_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed DIV/DIVU vectors, divide by zero,
// annul mid-division and asynchronous reset mid-division.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          signed_div = 1'b0;
  logic          annul = 1'b0;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic [63:0]   result;
  logic          ready;
  logic          stall_req;
  div_state_e    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (op1),
    .opdata2    (op2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lat = rising edges after the edge that accepts start until ready is seen.
  task automatic run_div(input string tag, input logic sd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] exp, input int exp_lat);
    int   lat;
    logic stall_gap;
    @(negedge clk);
    start = 1'b1; signed_div = sd; op1 = a; op2 = b;
    #1 check({tag, " stall_on_start"}, 64'(stall_req), 64'd1);
    @(posedge clk);
    #1;
    // operands must have been latched at the accepting edge
    op1 = $urandom; op2 = $urandom; signed_div = ~sd;
    lat = 0;
    stall_gap = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!ready && !stall_req) stall_gap = 1'b1;
    end while (!ready && lat < 100);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " stall_gap"}, 64'(stall_gap), 64'd0);
    check({tag, " stall_at_ready"}, 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready_drop"}, 64'(ready), 64'd0);
    check({tag, " back_idle"}, 64'(dbg_state), 64'(DIV_IDLE));
    check({tag, " result_held"}, result, exp);
  endtask

  initial begin
    int   seen_ready;

    #12;
    check("rst ready", 64'(ready), 64'd0);
    check("rst result", result, 64'd0);
    check("rst stall", 64'(stall_req), 64'd0);
    check("rst state", 64'(dbg_state), 64'(DIV_IDLE));
    @(negedge clk);
    rst = 1'b0;

    run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
    run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("div_7_m2",    1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
    run_div("div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
    run_div("divu_big",    1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33);
    run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 33);
    // DZERO after the accepting edge, DONE (ready) after the next one
    run_div("div_5_0",     1'b1, 32'd5,          32'd0,          64'h0,                 1);

    // Annul at iteration 10
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 check("annul busy_before", 64'(dbg_state), 64'(DIV_BUSY));
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul to_idle", 64'(dbg_state), 64'(DIV_IDLE));
    check("annul ready", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    seen_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (ready) seen_ready++;
    end
    check("annul never_ready", 64'(seen_ready), 64'd0);
    run_div("divu_9_3",    1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 33);

    // Asynchronous reset between clock edges, mid-BUSY
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst ready", 64'(ready), 64'd0);
    check("arst result", result, 64'd0);
    check("arst state", 64'(dbg_state), 64'(DIV_IDLE));
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    run_div("after_rst",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle restoring divider for MIPS DIV/DIVU, one stage upstream of the execute-stage ALU. It takes two 32-bit operands, runs one quotient bit per cycle, and returns {remainder, quotient} as a 64-bit word. The ALU forwards that word to HI/LO as hi=remainder and lo=quotient. While a division is in flight, the block holds the pipeline through `stall_req`.

## Interface
- `WIDTH`, 32: operand width. The result is 2*WIDTH. The iteration counter is $clog2(WIDTH)+1 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a division. Held high by the EX stage until `ready` is seen.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `opdata1` in WIDTH: dividend (rs). Sampled when `start` is accepted.
- `opdata2` in WIDTH: divisor (rt). Sampled when `start` is accepted.
- `annul` in 1: flush from exception or branch. Abandons the current division.
- `result` out 2*WIDTH: {remainder, quotient}. Valid while `ready`=1.
- `ready` out 1: result valid.
- `stall_req` out 1: equals `start & ~ready`. Combinational, and feeds the hazard unit.

## Operation
- FSM states: IDLE, DZERO, BUSY, DONE.
- **Reset:** state = IDLE, `result` = 0, `ready` = 0, counter = 0, internal registers = 0.
- **IDLE:**
  - If `start` & ~`annul` and `opdata2` == 0, go to DZERO.
  - If `start` & ~`annul` and `opdata2` != 0, go to BUSY. On entry:
    - Latch |`opdata1`| and |`opdata2`| (magnitudes only when `signed_div`, otherwise raw values).
    - Latch sign_q = s1^s2 and sign_r = s1, both forced to 0 for DIVU.
    - Clear the partial remainder and the counter.
- **BUSY** (one iteration per cycle):
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the divisor from rem[WIDTH:0].
  - If there is no borrow, take the difference and set quotient bit = 1. Otherwise keep rem and set the bit to 0.
  - After WIDTH iterations, go to DONE.
- **DONE:**
  - Apply signs: quotient negated if sign_q, remainder negated if sign_r.
  - `result` = {rem, quo}, `ready` = 1.
  - Stay in DONE while `start` = 1.
  - When `start` = 0, go to IDLE. `ready` drops. `result` keeps its value until the next accepted start.
- **DZERO:**
  - Result is fixed at 64'h0 (architecturally UNPREDICTABLE; the team defines it as zero).
  - Go to DONE after one cycle.
- **Annul:** `annul` = 1 in any state forces IDLE on the next edge. `ready` = 0 and the in-flight result is discarded. Annul has priority over `start`.
- **start low mid-operation:** deasserting `start` during BUSY/DZERO also aborts to IDLE, with the same behaviour as annul.
- **Overflow case:** signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) and remainder 0. No trap.
- **Arithmetic widths:** magnitudes are computed modulo 2^WIDTH, and the trial subtraction uses a WIDTH+1-bit adder.

## Timing
- Let `start` first be sampled high in IDLE at edge n.
- **Normal case:** BUSY occupies edges n+1..n+WIDTH. DONE is entered at edge n+WIDTH+1, and `ready` is high in the following cycle. That is 33 cycles for WIDTH=32.
- **Divide by zero:** DZERO after edge n, DONE after edge n+1, so `ready` is high 2 cycles after start.
- **Stall:** `stall_req` is high from the cycle `start` rises until the cycle `ready` is high, with no gap.
- **Back-to-back:** a new division needs `start` low for at least one cycle (DONE→IDLE), so minimum repeat time is WIDTH+3 cycles.
- **Async reset:** `rst` asserted at any time clears state and outputs immediately, independent of `clk`.

## Structure
- **Shared defines package:** state encodings (DIV_IDLE, DIV_DZERO, DIV_BUSY, DIV_DONE, 2 bits) and the constants DivResultReady/DivResultNotReady.
- EXE_DIV_OP/EXE_DIVU_OP stay in the shared defines. The EX stage derives `start` and `signed_div` from them.
- **Sub-module:** one, `div_step`, a combinational single-iteration shift/trial-subtract cell. The FSM, counter and sign correction stay in `div_unit`.

## Test plan
- **DIVU 100/7:** `ready` appears 33 cycles after start with `result` = 64'h00000002_0000000E, and `stall_req` is high for the whole interval.
- **DIV −7/2** (0xFFFFFFF9, 0x00000002): `result` = 64'hFFFFFFFF_FFFFFFFD (remainder −1, quotient −3).
- **0x80000000 / 0xFFFFFFFF:**
  - DIV gives 64'h00000000_80000000.
  - DIVU gives 64'h80000000_00000000.
- **Divide by zero** (DIV 5/0): `ready` high 2 cycles after start with `result` = 64'h0, then `start` low returns to IDLE.
- **Annul at iteration 10:** next cycle is IDLE, `ready` is never asserted. A following DIVU 9/3 returns 64'h00000000_00000003.
- **rst pulse mid-BUSY** (asynchronous, between clock edges): `ready`/`result` go to 0 immediately and the FSM is in IDLE.
